truth_table_sequencer: RTL and testbench
========================================

// Module: truth_table_sequencer
// PURPOSE
//  Sequencer that owns a shared 3-input function bank: on start it sweeps the input vector
//  {x,y,z} from 0 to 7, lets each vector settle, and samples the selected function output.
//  It assembles the sampled outputs into an 8-bit truth table.
//  Sits between the test/control logic and the combinational PoS function bank.
//  Replaces the bench-driven for-loop with a clocked, reusable evaluation engine.
// PARAMETERS
//  NFUNC   5  number of function outputs in the bank (func_out width)
//  SETTLE  1  clock cycles each vector is held before sampling (>=1)
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      synchronous, active-high
//  start     in   1      request a sweep; accepted only in IDLE
//  func_sel  in   3      bank output to sample; latched on start accept; values >=NFUNC sample 0
//  func_out  in   NFUNC  combinational outputs of the function bank for the current xyz
//  xyz       out  3      vector driven to the bank; bit2=x, bit1=y, bit0=z
//  busy      out  1      high from the start accept until done
//  done      out  1      one-cycle pulse when tt_out is valid
//  tt_out    out  8      truth table; bit i = f(xyz==i); held until next accept
//  expected  in   8      reference table (only with TT_CHECK_EN)
//  mismatch  out  1      tt_out != expected, valid with done (only with TT_CHECK_EN)
// BEHAVIOUR
//  - Reset (synchronous, wins over everything): state=IDLE; xyz=0; busy=0; done=0; tt_out=0;
//    mismatch=0; settle counter=0. Reset mid-sweep aborts without a done pulse.
//  - IDLE: start=1 -> latch func_sel, xyz<=0, tt_out<=0, cnt<=SETTLE-1, busy<=1, go HOLD.
//    start=0 -> stay in IDLE.
//  - HOLD: cnt!=0 -> cnt<=cnt-1. cnt==0 -> tt_out[xyz]<=func_out[sel].
//    Then, if xyz==7, go DONE; else xyz<=xyz+1, cnt<=SETTLE-1.
//  - DONE: done=1 and busy=0 for exactly one cycle; xyz is held at 7; go IDLE.
//    A start seen in DONE is ignored; requesters re-assert start in IDLE.
//  - start in HOLD is ignored. func_sel changes after the accept have no effect.
//  - xyz is a 3-bit counter; the 7->0 wrap never occurs inside a sweep.
//  - Latency: accept at edge E0; done is high in the cycle after edge E0+8*SETTLE.
//    SETTLE=1 gives 9 cycles from accept to done.
//  - tt_out may be observed mid-sweep (partial bits); it is valid only while done=1 or in IDLE.
// CONFIGURATION
//  TT_CHECK_EN defined:
//   - expected and mismatch ports exist.
//   - mismatch <= (final tt_out != expected), registered on the DONE transition.
//   - mismatch is held until the next accept, which clears it.
//  TT_CHECK_EN undefined:
//   - expected and mismatch are absent; no comparator logic.
// STRUCTURE
//  - Package tt_pkg: state typedef {IDLE, HOLD, DONE}; localparam NVEC=8; localparam VEC_W=3.
//  - Sub-module pos_func_bank: wraps the five PoS functions (a..e) into func_out[4:0].
//    It is instantiated only by the top-level/bench, not inside the sequencer.
//  - Sequencer body: one state register, one settle counter ($clog2(SETTLE+1) bits),
//    the xyz counter and the tt_out register.
// TESTING
//  1. Reset, then idle 5 cycles -> xyz=0, busy=0, done=0, tt_out=0x00.
//  2. func_sel=4 (f_e, x^z), start 1 cycle, SETTLE=1 -> done at cycle 9, tt_out=0x5A.
//  3. func_sel=2 (f_c, y xnor z) -> tt_out=0x99.
//     func_sel=0 (f_a) -> tt_out=0xD5.
//     Each sweep: busy=1 for 8 cycles and xyz steps 0..7.
//  4. SETTLE=3, func_sel=4 -> xyz holds each value 3 cycles; done at cycle 25; tt_out=0x5A.
//  5. Assert reset when xyz=4 mid-sweep -> next cycle IDLE, tt_out=0, no done pulse.
//     Hold start high through a sweep -> the next sweep begins only after DONE->IDLE.
//  6. TT_CHECK_EN, func_sel=4:
//     expected=0x5A -> mismatch=0 with done.
//     expected=0x5B -> mismatch=1 with done, cleared on the next accept.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and sizes for the truth-table sequencer and its function bank.
// Optional comparator feature is enabled by defining TT_CHECK_EN.
package tt_pkg;
  localparam int NVEC  = 8;
  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DONE
  } state_t;
endpackage

// File: rtl/truth_table_sequencer_if.sv
// Control/bank bundle between the requester, the sequencer and the PoS function bank.
// The expected/mismatch pair exists only when TT_CHECK_EN is defined.
interface truth_table_sequencer_if #(
  parameter int NFUNC = 5
);
  import tt_pkg::*;

  logic             start;
  logic [2:0]       func_sel;
  logic [NFUNC-1:0] func_out;
  logic [VEC_W-1:0] xyz;
  logic             busy;
  logic             done;
  logic [NVEC-1:0]  tt_out;
`ifdef TT_CHECK_EN
  logic [NVEC-1:0]  expected;
  logic             mismatch;

  modport master (output start, func_sel, func_out, expected,
                  input  xyz, busy, done, tt_out, mismatch);
  modport slave  (input  start, func_sel, func_out, expected,
                  output xyz, busy, done, tt_out, mismatch);
`else
  modport master (output start, func_sel, func_out,
                  input  xyz, busy, done, tt_out);
  modport slave  (input  start, func_sel, func_out,
                  output xyz, busy, done, tt_out);
`endif
endinterface

// File: rtl/pos_func_bank.sv
// Five product-of-sums functions of {x,y,z}; bit k of func_out is function a+k.
// Purely combinational; the sequencer sweeps xyz and samples one output.
module pos_func_bank
  import tt_pkg::*;
(
  input  logic [VEC_W-1:0] xyz,
  output logic [4:0]       func_out
);
  logic x, y, z;
  assign {x, y, z} = xyz;

  assign func_out[0] = (x | ~z) & (y | ~z);          // f_a
  assign func_out[1] = (x | y) & (~x | z);           // f_b
  assign func_out[2] = (y | ~z) & (~y | z);          // f_c, y xnor z
  assign func_out[3] = (x | y | z) & (~x | ~y);      // f_d
  assign func_out[4] = (x | z) & (~x | ~z);          // f_e, x ^ z
endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps xyz 0..7, holds each vector SETTLE cycles, samples the selected bank output
// into tt_out. Defining TT_CHECK_EN adds a registered compare against expected.
module truth_table_sequencer
  import tt_pkg::*;
#(
  parameter int NFUNC  = 5,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  truth_table_sequencer_if.slave bus
);
  localparam int               CNT_W      = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NVEC - 1);

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] xyz_q, xyz_d;
  logic [NVEC-1:0]  tt_q, tt_d, tt_sample;
  logic             sample;
`ifdef TT_CHECK_EN
  logic             mismatch_q, mismatch_d;
`endif

  // Selections beyond the bank width read as constant 0.
  assign sample = (int'(sel_q) < NFUNC) ? bus.func_out[sel_q] : 1'b0;

  // NOTE: every always_comb output gets its default first so no latch is inferred.
  always_comb begin
    tt_sample        = tt_q;
    tt_sample[xyz_q] = sample;

    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    xyz_d   = xyz_q;
    tt_d    = tt_q;
`ifdef TT_CHECK_EN
    mismatch_d = mismatch_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sel_d   = bus.func_sel;
          xyz_d   = '0;
          tt_d    = '0;
          cnt_d   = CNT_RELOAD;
          state_d = HOLD;
`ifdef TT_CHECK_EN
          mismatch_d = 1'b0;
`endif
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          tt_d = tt_sample;
          if (xyz_q == LAST_VEC) begin
            state_d = DONE;
`ifdef TT_CHECK_EN
            mismatch_d = (tt_sample != bus.expected);
`endif
          end else begin
            xyz_d = xyz_q + VEC_W'(1);
            cnt_d = CNT_RELOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      xyz_q   <= '0;
      tt_q    <= '0;
`ifdef TT_CHECK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      xyz_q   <= xyz_d;
      tt_q    <= tt_d;
`ifdef TT_CHECK_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign bus.xyz    = xyz_q;
  assign bus.tt_out = tt_q;
  assign bus.busy   = (state_q == HOLD);
  assign bus.done   = (state_q == DONE);
`ifdef TT_CHECK_EN
  assign bus.mismatch = mismatch_q;
`endif
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with SETTLE=1 and SETTLE=3 instances.
// Comparator checks are compiled in when TT_CHECK_EN is defined.
module tb_truth_table_sequencer;
  import tt_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  truth_table_sequencer_if #(.NFUNC(5)) if1 ();
  truth_table_sequencer_if #(.NFUNC(5)) if3 ();

  pos_func_bank bank1 (.xyz(if1.xyz), .func_out(if1.func_out));
  pos_func_bank bank3 (.xyz(if3.xyz), .func_out(if3.func_out));

  truth_table_sequencer #(.NFUNC(5), .SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  truth_table_sequencer #(.NFUNC(5), .SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];

  // View of whichever instance the current step targets.
  int         cur = 1;
  logic       m_done, m_busy;
  logic [2:0] m_xyz;
  logic [7:0] m_tt;
  always_comb begin
    m_done = (cur == 1) ? if1.done   : if3.done;
    m_busy = (cur == 1) ? if1.busy   : if3.busy;
    m_xyz  = (cur == 1) ? if1.xyz    : if3.xyz;
    m_tt   = (cur == 1) ? if1.tt_out : if3.tt_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the request is accepted on the next rising edge.
  task automatic drive_start(input int w, input logic [2:0] sel, input logic [7:0] exp,
                             input bit hold);
    cur = w;
    sb_q.push_back(exp);
    if (w == 1) begin if1.func_sel = sel; if1.start = 1'b1; end
    else        begin if3.func_sel = sel; if3.start = 1'b1; end
    @(negedge clk);
    if (!hold) begin
      if (w == 1) begin if1.start = 1'b0; if1.func_sel = ~sel; end
      else        begin if3.start = 1'b0; if3.func_sel = ~sel; end
    end
  endtask

  // Entered at the falling edge right after the accept (cycle 1 of the sweep).
  task automatic wait_done(input int settle, input string tag);
    int         n      = 1;
    int         busy_n = 0;
    bit         seq_ok = 1'b1;
    logic [7:0] exp;
    while (!m_done && n < 400) begin
      if (m_busy) busy_n++;
      if (m_xyz !== 3'((n - 1) / settle)) seq_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 8 * settle + 1);
    check({tag, "_busy_cycles"}, busy_n, 8 * settle);
    check({tag, "_xyz_steps"}, {31'd0, seq_ok}, 1);
    check({tag, "_busy_at_done"}, {31'd0, m_busy}, 0);
    check({tag, "_xyz_at_done"}, {29'd0, m_xyz}, 7);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
    check({tag, "_tt"}, {24'd0, m_tt}, {24'd0, exp});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, m_done}, 0);
    check({tag, "_tt_held"}, {24'd0, m_tt}, {24'd0, exp});
  endtask

  initial begin
    int guard;
    int dn;
    reset        = 1'b1;
    if1.start    = 1'b0;
    if1.func_sel = '0;
    if3.start    = 1'b0;
    if3.func_sel = '0;
`ifdef TT_CHECK_EN
    if1.expected = '0;
    if3.expected = '0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    check("rst_xyz", {29'd0, if1.xyz}, 0);
    check("rst_busy", {31'd0, if1.busy}, 0);
    check("rst_done", {31'd0, if1.done}, 0);
    check("rst_tt", {24'd0, if1.tt_out}, 0);
    check("rst_tt_s3", {24'd0, if3.tt_out}, 0);
`ifdef TT_CHECK_EN
    check("rst_mismatch", {31'd0, if1.mismatch}, 0);
`endif

    // Sweeps over each bank function plus out-of-range selects.
    drive_start(1, 3'd4, 8'h5A, 1'b0); wait_done(1, "fe");
    drive_start(1, 3'd2, 8'h99, 1'b0); wait_done(1, "fc");
    drive_start(1, 3'd0, 8'hD5, 1'b0); wait_done(1, "fa");
    drive_start(1, 3'd1, 8'hAC, 1'b0); wait_done(1, "fb");
    drive_start(1, 3'd3, 8'h3E, 1'b0); wait_done(1, "fd");
    drive_start(1, 3'd5, 8'h00, 1'b0); wait_done(1, "sel5");
    drive_start(1, 3'd7, 8'h00, 1'b0); wait_done(1, "sel7");

    drive_start(3, 3'd4, 8'h5A, 1'b0); wait_done(3, "s3_fe");

    // Reset at xyz==4 aborts the sweep without a done pulse.
    drive_start(1, 3'd4, 8'h5A, 1'b0);
    guard = 0;
    while (if1.xyz !== 3'd4 && guard < 50) begin @(negedge clk); guard++; end
    check("abort_reach_xyz4", {29'd0, if1.xyz}, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb_q.pop_front());
    check("abort_busy", {31'd0, if1.busy}, 0);
    check("abort_done", {31'd0, if1.done}, 0);
    check("abort_xyz", {29'd0, if1.xyz}, 0);
    check("abort_tt", {24'd0, if1.tt_out}, 0);
    dn = 0;
    repeat (15) begin
      if (if1.done) dn++;
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);

    // Start held high: no accept in DONE, next sweep starts from IDLE.
    drive_start(1, 3'd2, 8'h99, 1'b1);
    wait_done(1, "hold1");
    check("hold_idle_gap", {31'd0, if1.busy}, 0);
    @(negedge clk);
    check("hold_reaccept", {31'd0, if1.busy}, 1);
    if1.start = 1'b0;
    sb_q.push_back(8'h99);
    wait_done(1, "hold2");

`ifdef TT_CHECK_EN
    if1.expected = 8'h5A;
    drive_start(1, 3'd4, 8'h5A, 1'b0); wait_done(1, "chk_match");
    check("chk_match_mm", {31'd0, if1.mismatch}, 0);
    if1.expected = 8'h5B;
    drive_start(1, 3'd4, 8'h5A, 1'b0); wait_done(1, "chk_diff");
    check("chk_diff_mm", {31'd0, if1.mismatch}, 1);
    @(negedge clk);
    check("chk_diff_held", {31'd0, if1.mismatch}, 1);
    if1.expected = 8'h5A;
    drive_start(1, 3'd4, 8'h5A, 1'b0);
    check("chk_clear_on_accept", {31'd0, if1.mismatch}, 0);
    wait_done(1, "chk_again");
    check("chk_again_mm", {31'd0, if1.mismatch}, 0);
`endif

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
